// File: rtl/fft_pair_sequencer.sv
// Frame buffer and radix-2 butterfly operand sequencer: captures SAMPLES words, then
// streams (x[a], x[b]) pairs with indices, stage and twiddle for one or all stages.
module fft_pair_sequencer #(
    parameter int SAMPLES = 8,
    parameter int WIDTH   = 16,
    localparam int LOG    = $clog2(SAMPLES),
    localparam int IDXW   = LOG,
    localparam int SW     = ($clog2(LOG) > 0) ? $clog2(LOG) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             start,
    input  logic [SW-1:0]    stage_sel,
    input  logic             all_stages,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic [WIDTH-1:0] out_b_data,
    output logic [IDXW-1:0]  out_a_idx,
    output logic [IDXW-1:0]  out_b_idx,
    output logic [SW-1:0]    out_stage,
    output logic [IDXW-1:0]  out_twiddle,
    output logic             out_stage_last,
    output logic             out_last
);
    localparam logic [IDXW-1:0] LAST_PAIR = IDXW'(SAMPLES / 2 - 1);
    localparam logic [SW-1:0]   TOP_STAGE = SW'(LOG - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FULL, EMIT} state_t;

    typedef struct packed {
        logic [IDXW-1:0] a;
        logic [IDXW-1:0] b;
        logic [IDXW-1:0] tw;
    } pair_t;

    state_t           state_q, state_d;
    logic [LOG:0]     wr_cnt;
    logic [WIDTH-1:0] frame_mem [SAMPLES];
    logic [SW-1:0]    last_stage, final_stage, start_stage, sel_stage, nxt_stage;
    logic [IDXW-1:0]  pair_q, sel_pair, nxt_pair;
    logic             accept, hs, load_en, sel_last;
    pair_t            pr;

    function automatic logic [SW-1:0] clamp_stage(input logic [SW-1:0] s);
        return (int'(s) >= LOG) ? TOP_STAGE : s;
    endfunction

    // Pair p of stage s: p = g*2^s + j, so the group and in-group offset fall out of shifts.
    function automatic pair_t gen_pair(input logic [SW-1:0] s, input logic [IDXW-1:0] p);
        pair_t           r;
        logic [IDXW-1:0] j;
        logic [IDXW-1:0] g;
        j    = p & ((IDXW'(1) << s) - IDXW'(1));
        g    = p >> s;
        r.a  = ((g << s) << 1) | j;
        r.b  = r.a | (IDXW'(1) << s);
        r.tw = j << (LOG - 1 - int'(s));
        return r;
    endfunction

    assign accept = in_ready && in_valid;
    assign hs     = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    if (accept && wr_cnt == (LOG+1)'(SAMPLES - 1)) state_d = FULL;
            FULL:    if (start) state_d = EMIT;
            EMIT:    if (hs && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == LOAD);
        busy     = (state_q == EMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      wr_cnt <= '0;
        else if (state_q == EMIT && state_d == IDLE) wr_cnt <= '0;
        else if (accept)                   wr_cnt <= wr_cnt + (LOG+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (accept) frame_mem[wr_cnt[LOG-1:0]] <= in_data;
    end

    // Select the pair to present next: the first pair on start, else the successor.
    always_comb begin
        start_stage = all_stages ? '0 : clamp_stage(stage_sel);
        nxt_stage   = out_stage;
        nxt_pair    = pair_q + IDXW'(1);
        if (pair_q == LAST_PAIR) begin
            nxt_pair  = '0;
            nxt_stage = out_stage + SW'(1);
        end
        if (state_q == FULL) begin
            sel_stage   = start_stage;
            sel_pair    = '0;
            final_stage = all_stages ? TOP_STAGE : start_stage;
        end else begin
            sel_stage   = nxt_stage;
            sel_pair    = nxt_pair;
            final_stage = last_stage;
        end
        sel_last = (sel_pair == LAST_PAIR) && (sel_stage == final_stage);
        load_en  = (state_q == FULL && start) || (state_q == EMIT && hs && !out_last);
        pr       = gen_pair(sel_stage, sel_pair);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            done           <= 1'b0;
            out_a_data     <= '0;
            out_b_data     <= '0;
            out_a_idx      <= '0;
            out_b_idx      <= '0;
            out_stage      <= '0;
            out_twiddle    <= '0;
            out_stage_last <= 1'b0;
            out_last       <= 1'b0;
            pair_q         <= '0;
            last_stage     <= '0;
        end else begin
            done <= 1'b0;
            if (load_en) begin
                out_valid      <= 1'b1;
                out_a_data     <= frame_mem[pr.a];
                out_b_data     <= frame_mem[pr.b];
                out_a_idx      <= pr.a;
                out_b_idx      <= pr.b;
                out_stage      <= sel_stage;
                out_twiddle    <= pr.tw;
                out_stage_last <= (sel_pair == LAST_PAIR);
                out_last       <= sel_last;
                pair_q         <= sel_pair;
                last_stage     <= final_stage;
            end else if (hs && out_last) begin
                out_valid <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

endmodule
